// File: rtl/nn_sched_pkg.sv
// Shared types and register-map constants for the NN input scheduler.
package nn_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_STREAM    = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_DONE      = 2'd3
  } sched_state_e;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_LEN    = 2'd3;

  localparam int unsigned STAT_STATE_LSB = 0;
  localparam int unsigned STAT_EMPTY     = 2;
  localparam int unsigned STAT_FULL      = 3;
  localparam int unsigned STAT_OVERFLOW  = 4;
  localparam int unsigned STAT_DONE      = 5;
  localparam int unsigned STAT_LEVEL_LSB = 8;
  localparam int unsigned STAT_SENT_LSB  = 16;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_CLEAR = 1;

endpackage

// File: rtl/nn_sched_fifo.sv
// Synchronous show-ahead FIFO; dout is the current head, flush empties it.
module nn_sched_fifo #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  localparam int unsigned AW        = $clog2(FIFO_DEPTH),
  localparam int unsigned LVL_W     = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [LVL_W-1:0]  level
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [LVL_W-1:0]  count;
  logic              pop_ok;
  logic              push_ok;

  always_comb begin
    empty   = (count == '0);
    full    = (count == LVL_W'(FIFO_DEPTH));
    level   = count;
    dout    = mem[rd_ptr];
    pop_ok  = pop && !empty && !flush;
    // A full FIFO still accepts a word when a pop frees a slot in the same cycle.
    push_ok = push && (!full || pop_ok) && !flush;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nn_input_scheduler.sv
// Avalon-MM buffered frame streamer for the NN core.
// Optional interrupt output enabled by defining NN_SCHED_IRQ_EN.
module nn_input_scheduler
  import nn_sched_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LEN_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
`ifdef NN_SCHED_IRQ_EN
  output logic              irq,
`endif
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic [DATA_W-1:0] nn_data,
  output logic              nn_valid,
  input  logic              nn_ready,
  output logic              nn_last,
  input  logic              nn_done
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  sched_state_e      state_q, state_d;
  logic [LEN_W-1:0]  frame_len_q;
  logic [LEN_W-1:0]  active_len_q;
  logic [LEN_W-1:0]  words_sent_q;
  logic              overflow_q;
  logic              done_q;

  logic [DATA_W-1:0] fifo_head;
  logic              fifo_empty;
  logic              fifo_full;
  logic [LVL_W-1:0]  fifo_level;

  logic              wr_en, wr_data, wr_ctrl, wr_stat, wr_len;
  logic              clear, start_ok, xfer, overflow_evt, done_evt;
  logic [31:0]       status;
  logic [DATA_W-1:0] readdata_d;

  always_comb begin
    wr_en        = chipselect && !write_n;
    wr_data      = wr_en && (address == ADDR_DATA);
    wr_ctrl      = wr_en && (address == ADDR_CTRL);
    wr_stat      = wr_en && (address == ADDR_STATUS);
    wr_len       = wr_en && (address == ADDR_LEN);
    clear        = wr_ctrl && writedata[CTRL_CLEAR];
    start_ok     = wr_ctrl && writedata[CTRL_START] && !writedata[CTRL_CLEAR]
                   && ((state_q == ST_IDLE) || (state_q == ST_DONE))
                   && (frame_len_q != '0);
    nn_valid     = (state_q == ST_STREAM) && !fifo_empty;
    nn_last      = nn_valid && (words_sent_q == active_len_q - LEN_W'(1));
    nn_data      = fifo_empty ? '0 : fifo_head;
    xfer         = nn_valid && nn_ready;
    overflow_evt = wr_data && fifo_full && !xfer;
    done_evt     = (state_q == ST_WAIT_DONE) && nn_done && !clear;
  end

  nn_sched_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (clear),
    .push  (wr_data),
    .din   (writedata),
    .pop   (xfer),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (start_ok) state_d = ST_STREAM;
        ST_STREAM:        if (xfer && nn_last) state_d = ST_WAIT_DONE;
        ST_WAIT_DONE:     if (nn_done) state_d = ST_DONE;
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_len_q  <= '0;
      active_len_q <= '0;
      words_sent_q <= '0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      if (wr_len) frame_len_q <= writedata[LEN_W-1:0];
      if (clear) begin
        words_sent_q <= '0;
        overflow_q   <= 1'b0;
        done_q       <= 1'b0;
      end else begin
        if (start_ok) begin
          active_len_q <= frame_len_q;
          words_sent_q <= '0;
          done_q       <= 1'b0;
        end else if (xfer) begin
          words_sent_q <= words_sent_q + LEN_W'(1);
        end
        if (overflow_evt) overflow_q <= 1'b1;
        if (done_evt)     done_q     <= 1'b1;
      end
    end
  end

  always_comb begin
    status                                 = '0;
    status[STAT_STATE_LSB +: 2]            = state_q;
    status[STAT_EMPTY]                     = fifo_empty;
    status[STAT_FULL]                      = fifo_full;
    status[STAT_OVERFLOW]                  = overflow_q;
    status[STAT_DONE]                      = done_q;
    status[STAT_LEVEL_LSB +: 8]            = 8'(fifo_level);
    status[STAT_SENT_LSB +: 16]            = 16'(words_sent_q);
    readdata_d                             = '0;
    case (address)
      ADDR_STATUS: readdata_d = DATA_W'(status);
      ADDR_LEN:    readdata_d = DATA_W'(frame_len_q);
      default:     readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= '0;
    else       readdata <= readdata_d;
  end

`ifdef NN_SCHED_IRQ_EN
  // Set events take priority over a same-cycle acknowledge so no event is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        irq <= 1'b0;
    else if (done_evt || overflow_evt) irq <= 1'b1;
    else if (wr_stat || clear)         irq <= 1'b0;
  end
`else
  logic unused_wr_stat;
  assign unused_wr_stat = wr_stat;
`endif

endmodule
